up_down_count_monitor: RTL and testbench

//  Observer on the far end of the up_down_counter interface: samples the counter

---
 rtl/up_down_count_pkg.sv | 24 ++
 rtl/up_down_count_monitor_sat_counter.sv | 19 +
 rtl/up_down_count_monitor.sv | 126 ++++++++++++
 tb/tb_up_down_count_monitor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_count_pkg.sv
// Shared types and the step-legality check for the up/down counter monitor.
package up_down_count_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } mon_state_t;

  localparam int unsigned MAX_W = 32;

  // Values are passed zero-extended to MAX_W; width selects how many low bits take part.
  function automatic logic step_ok(input logic [MAX_W-1:0] prev,
                                   input logic [MAX_W-1:0] cur,
                                   input logic             up,
                                   input int unsigned      width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] nxt;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    nxt  = up ? (prev + 32'd1) : (prev - 32'd1);
    return ((nxt ^ cur) & mask) == '0;
  endfunction

endpackage

// File: rtl/up_down_count_monitor_sat_counter.sv
// Saturating event counter: holds at all-ones, synchronous clear has priority.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/up_down_count_monitor.sv
// Observes an up/down counter and its direction control; tracks lock on +/-1 steps,
// flags wraps and illegal steps, and predicts the next counter value.
module up_down_count_monitor
  import up_down_count_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_CYCLES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up_down,
  input  logic [WIDTH-1:0]     counter,
  output logic                 locked,
  output logic                 dir_obs,
  output logic                 wrap,
  output logic                 step_err,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MW = $clog2(SYNC_CYCLES + 1);

  mon_state_t       state;
  mon_state_t       state_nx;
  logic [WIDTH-1:0] prev;
  logic             up_down_q;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_nx;
  logic             legal;
  logic             at_edge;
  logic             sync_done;
  logic             locked_nx;
  logic             dir_nx;
  logic             wrap_nx;
  logic             err_nx;

  // The step is judged against the direction registered alongside prev, so a
  // direction change only applies from the sample after it was captured.
  assign legal     = step_ok(32'(prev), 32'(counter), up_down_q, WIDTH);
  assign at_edge   = up_down_q ? (prev == '1) : (prev == '0);
  assign sync_done = (int'(match_cnt) + 1) >= SYNC_CYCLES;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = ACQUIRE;
      ACQUIRE: if (legal && sync_done) state_nx = TRACK;
      TRACK:   if (!legal) state_nx = ACQUIRE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    match_nx  = match_cnt;
    locked_nx = locked;
    dir_nx    = dir_obs;
    wrap_nx   = 1'b0;
    err_nx    = 1'b0;
    unique case (state)
      ACQUIRE: begin
        if (!legal) begin
          match_nx = '0;
        end else if (sync_done) begin
          match_nx  = '0;
          locked_nx = 1'b1;
        end else begin
          match_nx = match_cnt + MW'(1);
        end
      end
      TRACK: begin
        if (!legal) begin
          err_nx    = 1'b1;
          locked_nx = 1'b0;
          match_nx  = '0;
        end
      end
      default: ;
    endcase
    // Wrap and step_err are exclusive: wrap needs a legal step, step_err an illegal one.
    if ((state != IDLE) && legal) begin
      dir_nx  = up_down_q;
      wrap_nx = at_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev      <= '0;
      up_down_q <= 1'b0;
      match_cnt <= '0;
      locked    <= 1'b0;
      dir_obs   <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      expected  <= '0;
    end else begin
      prev      <= counter;
      up_down_q <= up_down;
      match_cnt <= match_nx;
      locked    <= locked_nx;
      dir_obs   <= dir_nx;
      wrap      <= wrap_nx;
      step_err  <= err_nx;
      expected  <= up_down ? (counter + WIDTH'(1)) : (counter - WIDTH'(1));
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .en (err_nx),
    .clr(!reset),
    .cnt(err_count)
  );

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Scoreboarded bench for up_down_count_monitor (ERR_CNT_W=8 and ERR_CNT_W=2 instances).
module tb_up_down_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       up_down = 1'b0;
  logic [3:0] counter = 4'd0;

  logic       locked, dir_obs, wrap, step_err;
  logic [3:0] expected;
  logic [7:0] err_count;
  logic       locked2, dir_obs2, wrap2, step_err2;
  logic [3:0] expected2;
  logic [1:0] err_count2;

  up_down_count_monitor #(.WIDTH(4), .SYNC_CYCLES(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .up_down(up_down), .counter(counter),
    .locked(locked), .dir_obs(dir_obs), .wrap(wrap), .step_err(step_err),
    .expected(expected), .err_count(err_count)
  );

  up_down_count_monitor #(.WIDTH(4), .SYNC_CYCLES(2), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .up_down(up_down), .counter(counter),
    .locked(locked2), .dir_obs(dir_obs2), .wrap(wrap2), .step_err(step_err2),
    .expected(expected2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       locked;
    logic       dir;
    logic       wrap;
    logic       serr;
    logic [3:0] exp_val;
    logic [7:0] err8;
    logic [1:0] err2;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state (what the monitor should hold after each edge)
  int         m_state = 0;
  logic [3:0] m_prev = 4'd0;
  logic       m_udq = 1'b0;
  int         m_match = 0;
  logic       m_locked = 1'b0;
  logic       m_dir = 1'b0;
  logic       m_wrap = 1'b0;
  logic       m_serr = 1'b0;
  logic [3:0] m_exp = 4'd0;
  int         m_err = 0;

  task automatic drive(input logic rst_n, input logic [3:0] cnt, input logic ud);
    exp_t       e;
    logic [3:0] stepped;
    logic       ok;
    int         st;
    reset   = rst_n;
    counter = cnt;
    up_down = ud;
    if (!rst_n) begin
      m_state = 0; m_prev = 4'd0; m_udq = 1'b0; m_match = 0; m_locked = 1'b0;
      m_dir = 1'b0; m_wrap = 1'b0; m_serr = 1'b0; m_exp = 4'd0; m_err = 0;
    end else begin
      stepped = m_udq ? m_prev + 4'd1 : m_prev - 4'd1;
      ok      = (cnt == stepped);
      st      = m_state;
      m_wrap  = 1'b0;
      m_serr  = 1'b0;
      if (st == 0) begin
        m_state = 1;
      end else if (st == 1) begin
        if (ok) begin
          m_match = m_match + 1;
          if (m_match == 2) begin
            m_state = 2; m_locked = 1'b1; m_match = 0;
          end
        end else begin
          m_match = 0;
        end
      end else if (!ok) begin
        m_serr = 1'b1; m_err = m_err + 1; m_locked = 1'b0; m_match = 0; m_state = 1;
      end
      if (st != 0 && ok) begin
        m_dir  = m_udq;
        m_wrap = m_udq ? (m_prev == 4'd15) : (m_prev == 4'd0);
      end
      m_exp  = ud ? cnt + 4'd1 : cnt - 4'd1;
      m_prev = cnt;
      m_udq  = ud;
    end
    e.locked  = m_locked;
    e.dir     = m_dir;
    e.wrap    = m_wrap;
    e.serr    = m_serr;
    e.exp_val = m_exp;
    e.err8    = (m_err > 255) ? 8'd255 : 8'(m_err);
    e.err2    = (m_err > 3) ? 2'd3 : 2'(m_err);
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every driven sample is compared one step after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      n_vec++; if (locked !== e.locked) begin n_fail++; $display("FAIL sb_locked: got %0b want %0b", locked, e.locked); end
      n_vec++; if (dir_obs !== e.dir) begin n_fail++; $display("FAIL sb_dir_obs: got %0b want %0b", dir_obs, e.dir); end
      n_vec++; if (wrap !== e.wrap) begin n_fail++; $display("FAIL sb_wrap: got %0b want %0b", wrap, e.wrap); end
      n_vec++; if (step_err !== e.serr) begin n_fail++; $display("FAIL sb_step_err: got %0b want %0b", step_err, e.serr); end
      n_vec++; if (expected !== e.exp_val) begin n_fail++; $display("FAIL sb_expected: got %0d want %0d", expected, e.exp_val); end
      n_vec++; if (err_count !== e.err8) begin n_fail++; $display("FAIL sb_err_count: got %0d want %0d", err_count, e.err8); end
      n_vec++; if (err_count2 !== e.err2) begin n_fail++; $display("FAIL sb_err_count_w2: got %0d want %0d", err_count2, e.err2); end
      n_vec++; if (step_err2 !== e.serr || locked2 !== e.locked) begin
        n_fail++; $display("FAIL sb_dut2_ctrl: got serr=%0b locked=%0b want serr=%0b locked=%0b", step_err2, locked2, e.serr, e.locked);
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 4'd7, 1'b1);
    drive(1'b0, 4'd9, 1'b0);
    n_vec++; if ({locked, dir_obs, wrap, step_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {locked, dir_obs, wrap, step_err}); end
    n_vec++; if (expected !== 4'd0 || err_count !== 8'd0) begin n_fail++; $display("FAIL reset_values: got exp=%0d err=%0d want 0 0", expected, err_count); end
    n_vec++; if (dut.state !== up_down_count_pkg::IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_count_up();
    drive(1'b1, 4'd0, 1'b1);
    drive(1'b1, 4'd1, 1'b1);
    n_vec++; if (locked !== 1'b0) begin n_fail++; $display("FAIL up_early_lock: got %0b want 0", locked); end
    drive(1'b1, 4'd2, 1'b1);
    n_vec++; if (locked !== 1'b1) begin n_fail++; $display("FAIL up_lock: got %0b want 1", locked); end
    drive(1'b1, 4'd3, 1'b1);
    n_vec++; if (dir_obs !== 1'b1 || expected !== 4'd4) begin n_fail++; $display("FAIL up_dir_exp: got dir=%0b exp=%0d want 1 4", dir_obs, expected); end
  endtask

  task automatic test_wrap_up();
    int serr_seen = 0;
    drive(1'b0, 4'd0, 1'b1);
    for (int v = 12; v <= 15; v++) begin
      drive(1'b1, 4'(v), 1'b1);
      serr_seen += int'(step_err);
    end
    n_vec++; if (wrap !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL wrap_pre: got wrap=%0b locked=%0b want 0 1", wrap, locked); end
    drive(1'b1, 4'd0, 1'b1);
    serr_seen += int'(step_err);
    n_vec++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_up_pulse: got %0b want 1", wrap); end
    drive(1'b1, 4'd1, 1'b1);
    serr_seen += int'(step_err);
    n_vec++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_up_len: got %0b want 0", wrap); end
    n_vec++; if (serr_seen != 0) begin n_fail++; $display("FAIL wrap_up_no_err: got %0d step_err want 0", serr_seen); end
  endtask

  task automatic test_count_down();
    drive(1'b0, 4'd0, 1'b0);
    drive(1'b1, 4'd3, 1'b0);
    drive(1'b1, 4'd2, 1'b0);
    drive(1'b1, 4'd1, 1'b0);
    drive(1'b1, 4'd0, 1'b0);
    n_vec++; if (dir_obs !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL down_pre: got dir=%0b wrap=%0b want 0 0", dir_obs, wrap); end
    drive(1'b1, 4'd15, 1'b0);
    n_vec++; if (wrap !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got wrap=%0b locked=%0b want 1 1", wrap, locked); end
    // Direction flips: this sample is still judged as a down step.
    drive(1'b1, 4'd14, 1'b1);
    n_vec++; if (dir_obs !== 1'b0 || step_err !== 1'b0) begin n_fail++; $display("FAIL dir_lag: got dir=%0b serr=%0b want 0 0", dir_obs, step_err); end
    drive(1'b1, 4'd15, 1'b1);
    n_vec++; if (dir_obs !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL dir_switch: got dir=%0b locked=%0b want 1 1", dir_obs, locked); end
  endtask

  task automatic test_glitch_relock();
    drive(1'b0, 4'd0, 1'b1);
    for (int v = 3; v <= 6; v++) drive(1'b1, 4'(v), 1'b1);
    drive(1'b1, 4'd9, 1'b1);
    n_vec++; if (step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL glitch: got serr=%0b err=%0d locked=%0b want 1 1 0", step_err, err_count, locked);
    end
    drive(1'b1, 4'd10, 1'b1);
    n_vec++; if (step_err !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL glitch_len: got serr=%0b locked=%0b want 0 0", step_err, locked); end
    drive(1'b1, 4'd11, 1'b1);
    n_vec++; if (locked !== 1'b1 || err_count !== 8'd1) begin n_fail++; $display("FAIL relock: got locked=%0b err=%0d want 1 1", locked, err_count); end
    drive(1'b1, 4'd11, 1'b1);
    n_vec++; if (step_err !== 1'b1 || err_count !== 8'd2) begin n_fail++; $display("FAIL stall: got serr=%0b err=%0d want 1 2", step_err, err_count); end
  endtask

  task automatic test_saturate_and_reset();
    logic [3:0] v;
    int         pulses = 0;
    drive(1'b0, 4'd0, 1'b1);
    v = 4'd0;
    drive(1'b1, v, 1'b1);
    for (int i = 0; i < 2; i++) begin v = v + 4'd1; drive(1'b1, v, 1'b1); end
    for (int g = 0; g < 5; g++) begin
      v = v + 4'd3; drive(1'b1, v, 1'b1); pulses += int'(step_err2);
      v = v + 4'd1; drive(1'b1, v, 1'b1); pulses += int'(step_err2);
      v = v + 4'd1; drive(1'b1, v, 1'b1); pulses += int'(step_err2);
    end
    n_vec++; if (pulses != 5) begin n_fail++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
    n_vec++; if (err_count2 !== 2'd3 || err_count !== 8'd5) begin n_fail++; $display("FAIL sat_count: got w2=%0d w8=%0d want 3 5", err_count2, err_count); end
    n_vec++; if (locked2 !== 1'b1) begin n_fail++; $display("FAIL sat_tracking: got %0b want 1", locked2); end
    drive(1'b0, v + 4'd1, 1'b1);
    n_vec++; if (locked2 !== 1'b0 || err_count2 !== 2'd0 || dut2.state !== up_down_count_pkg::IDLE) begin
      n_fail++; $display("FAIL track_reset: got locked=%0b err=%0d state=%0d want 0 0 IDLE", locked2, err_count2, dut2.state);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_count_down();
    test_glitch_relock();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
